// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory behind the MEM-stage port.
// Holds the pipeline with busy for LATENCY wait cycles, then pulses ready.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [31:0]       ram [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              err_q, err_d;

    logic              req_any;
    logic              req_valid;
    logic              ram_we;
    logic              unused_addr_hi;

    assign req_any   = mem_read | mem_write;
    assign req_valid = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);

    // Upper address bits alias onto the RAM, so they are deliberately dropped.
    assign unused_addr_hi = ^{addr[31:ADDR_W+2]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        err_d      = 1'b0;
        ram_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_write_d = mem_write;
                    idx_d      = addr[ADDR_W+1:2];
                    wdata_d    = data_in;
                    cnt_d      = CNT_INIT;
                    state_d    = WAIT;
                end else if (req_any) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                // The access itself happens on the edge that leaves WAIT.
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (is_write_q) begin
                        ram_we = 1'b1;
                    end else begin
                        data_out_d = ram[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            data_out_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
        end
    end

    // RAM contents survive reset; ram_we is gated by the reset state register.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx_q] <= wdata_q;
        end
    end

    assign data_out = data_out_q;
    assign err      = err_q;
    assign ready    = (state_q == DONE);
    assign busy     = ((state_q == IDLE) && req_valid) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever ready or err pulses.
module tb_dmem_responder;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;
    logic        busy;
    logic        err;

    int checks;
    int failures;

    typedef struct {
        bit          is_err;
        logic [31:0] exp_data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_ram [int];
    logic [31:0] last_read;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready or err pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst && (ready || err)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_event", {30'd0, ready, err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("event_kind", {31'd0, err}, {31'd0, e.is_err});
                checkOutput("event_ready", {31'd0, ready}, {31'd0, !e.is_err});
                checkOutput("event_data_out", data_out, e.exp_data);
            end
        end
    end

    task automatic idleInputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'd0;
        data_in   = 32'd0;
    endtask

    // Valid access: checks busy/ready per cycle; hold keeps the request up through DONE.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input bit hold);
        exp_t e;
        int   idx;
        idx = int'(a[ADDR_W+1:2]);
        if (wr) model_ram[idx] = d;
        else last_read = model_ram[idx];
        e.is_err   = 1'b0;
        e.exp_data = last_read;
        exp_q.push_back(e);

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; data_in = d;
        for (int c = 0; c <= LATENCY + 1; c++) begin
            @(negedge clk);
            checkOutput($sformatf("busy_c%0d", c), {31'd0, busy}, {31'd0, c <= LATENCY});
            checkOutput($sformatf("ready_c%0d", c), {31'd0, ready}, {31'd0, c == LATENCY + 1});
            @(posedge clk); #1;
            if (!hold || c == LATENCY + 1) idleInputs();
        end
        if (hold) begin
            @(negedge clk);
            checkOutput("no_reexec_busy", {31'd0, busy}, 32'd0);
            checkOutput("no_reexec_ready", {31'd0, ready}, 32'd0);
        end
    endtask

    // Rejected request held for exactly one cycle.
    task automatic applyError(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_err   = 1'b1;
        e.exp_data = last_read;
        exp_q.push_back(e);

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; data_in = d;
        @(negedge clk);
        checkOutput("err_busy_c0", {31'd0, busy}, 32'd0);
        checkOutput("err_c0", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        checkOutput("err_c1", {31'd0, err}, 32'd1);
        checkOutput("err_busy_c1", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("err_c2", {31'd0, err}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        last_read = 32'd0;
        idleInputs();
        rst = 1'b0;
        #2;
        checkOutput("reset_data_out", data_out, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'h0,   32'h11111111, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h400, 32'h22222222, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0,   32'h0, 1'b0);

        applyError(1'b1, 1'b0, 32'h12, 32'h0);

        applyStimulus(1'b0, 1'b1, 32'h20, 32'h5A5A5A5A, 1'b0);
        applyError(1'b1, 1'b1, 32'h20, 32'hFFFF0000);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        @(posedge clk); #1;
        mem_write = 1'b1; addr = 32'h40; data_in = 32'h0BADF00D;
        @(posedge clk); #1;
        idleInputs();
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_data_out", data_out, 32'd0);
        checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_reset_ready", {31'd0, ready}, 32'd0);
        last_read = 32'd0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
